grf_wb_arbiter: RTL

GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

---
 rtl/grf_wb_arbiter_pkg.sv | 14 +
 rtl/grf_wb_arbiter_if.sv | 41 ++++
 rtl/grf_wb_arbiter_wb_fifo.sv | 80 ++++++++
 rtl/grf_wb_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types and default sizing for the register-file writeback arbiter.
package grf_wb_arbiter_pkg;

    localparam int unsigned DEFAULT_DEPTH        = 2;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

    // One deferred register-file write; addr == 0 marks an empty or killed write.
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bundle of pipeline, multi-cycle unit, write-port and hazard-query signals.
interface grf_wb_arbiter_if;

    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;

    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic        mdu_ready;

    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] w_pc;

    logic        stall_req;

    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_busy1;
    logic        q_busy2;

    // Pipeline / result producers and the decode stage.
    modport master (
        output pipe_addr, pipe_data, pipe_pc,
        output mdu_valid, mdu_addr, mdu_data, mdu_pc,
        output q_addr1, q_addr2,
        input  mdu_ready, w_addr, w_data, w_pc, stall_req, q_busy1, q_busy2
    );

    // The arbiter.
    modport slave (
        input  pipe_addr, pipe_data, pipe_pc,
        input  mdu_valid, mdu_addr, mdu_data, mdu_pc,
        input  q_addr1, q_addr2,
        output mdu_ready, w_addr, w_data, w_pc, stall_req, q_busy1, q_busy2
    );

endinterface

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Deferred-write queue: circular storage with push, pop, kill-by-address and
// an address-match query over occupied slots.
module wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             kill,
    input  logic [4:0]       kill_addr,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    input  logic [4:0]       match_addr1,
    input  logic [4:0]       match_addr2,
    output logic             match1,
    output logic             match2
);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage and pointer update; a push lands after kill/pop so a full-queue
    // push into the slot being popped keeps the new entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].addr == kill_addr) mem[i].addr <= '0;
                end
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= ptr_inc(rd_ptr);
            end
            if (push) begin
                mem[wr_ptr]   <= push_entry;
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

    // Hazard query: a zero address never matches, killed entries hold addr 0.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && match_addr1 != '0 && mem[i].addr == match_addr1) match1 = 1'b1;
            if (valid[i] && match_addr2 != '0 && mem[i].addr == match_addr2) match2 = 1'b1;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, deferred multi-cycle
// results drain through a small queue, and a starving queue head requests a
// pipeline bubble.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           reset,
    grf_wb_arbiter_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t         head;
    wb_entry_t         push_entry;
    logic [CNT_W-1:0]  count;
    logic              pipe_wr;
    logic              nonempty;
    logic              pop;
    logic              bypass;
    logic              accept;
    logic              push;
    logic              head_live;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              stall_q;
    logic              stall_d;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .kill        (pipe_wr),
        .kill_addr   (bus.pipe_addr),
        .head        (head),
        .count       (count),
        .match_addr1 (bus.q_addr1),
        .match_addr2 (bus.q_addr2),
        .match1      (bus.q_busy1),
        .match2      (bus.q_busy2)
    );

    // Write-port priority and result acceptance; everything is forced idle in reset.
    always_comb begin
        pipe_wr  = bus.pipe_addr != '0;
        nonempty = count != '0;
        pop      = !reset && !pipe_wr && nonempty;
        bypass   = !reset && !pipe_wr && !nonempty && bus.mdu_valid && bus.mdu_addr != '0;
        // A full queue still accepts when its head leaves this cycle.
        bus.mdu_ready = !reset && ((count < CNT_W'(DEPTH)) || pop || bypass);
        accept   = bus.mdu_valid && bus.mdu_ready;
        // Results to addr 0, or to the register the pipeline writes now, are dropped.
        push     = accept && !bypass && bus.mdu_addr != '0
                   && !(pipe_wr && bus.mdu_addr == bus.pipe_addr);
        push_entry = '{addr: bus.mdu_addr, data: bus.mdu_data, pc: bus.mdu_pc};

        bus.w_addr = '0;
        bus.w_data = '0;
        bus.w_pc   = '0;
        if (reset) begin
            bus.w_addr = '0;
        end else if (pipe_wr) begin
            bus.w_addr = bus.pipe_addr;
            bus.w_data = bus.pipe_data;
            bus.w_pc   = bus.pipe_pc;
        end else if (nonempty) begin
            bus.w_addr = head.addr;
            bus.w_data = head.data;
            bus.w_pc   = head.pc;
        end else if (bypass) begin
            bus.w_addr = bus.mdu_addr;
            bus.w_data = bus.mdu_data;
            bus.w_pc   = bus.mdu_pc;
        end
    end

    // Starvation tracking: count cycles a live head is blocked; the stall request
    // rises once the count has sat at the limit and drops after the head pops.
    always_comb begin
        head_live = nonempty && head.addr != '0;
        wait_d    = wait_q;
        if (pop || !nonempty) begin
            wait_d = '0;
        end else if (head_live && wait_q != WAIT_W'(STARVE_LIMIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        stall_d = stall_q;
        if (pop) begin
            stall_d = 1'b0;
        end else if (wait_q == WAIT_W'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end
    end

    // Starvation state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign bus.stall_req = stall_q;

endmodule
